button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner_pkg.sv | 20 ++
 rtl/button_conditioner_if.sv | 24 ++
 rtl/button_conditioner_debounce.sv | 100 ++++++++++
 rtl/button_conditioner.sv | 26 ++
 tb/tb_button_conditioner.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the push-button conditioner: per-button FSM state
// encodings and the counter-width helper.
package button_conditioner_pkg;

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  // Smallest width w with 2**w >= value, so a counter of that width reaches value-1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between the board pins and the conditioner: raw levels in,
// debounced level and one-cycle press pulse out.
interface button_conditioner_if #(
  parameter int NB_BTN = 3
);

  logic [NB_BTN-1:0] i_btn_raw;
  logic [NB_BTN-1:0] o_btn_pulse;
  logic [NB_BTN-1:0] o_btn_level;

  // master supplies raw buttons and consumes the conditioned outputs
  modport master (
    output i_btn_raw,
    input  o_btn_pulse,
    input  o_btn_level
  );

  modport slave (
    input  i_btn_raw,
    output o_btn_pulse,
    output o_btn_level
  );

endinterface

// File: rtl/button_conditioner_debounce.sv
// Single-button conditioner: 2-flop synchronizer, debounce FSM with stability
// counter, registered press pulse and debounced level.
module btn_debounce
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_pulse,
  output logic btn_level
);

  localparam int CNT_W = clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             btn_sync;
  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             count_done;
  logic             pulse_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
    end
  end

  assign btn_sync   = sync_q[1];
  assign count_done = (count == CNT_LAST);

  // Every state change clears the counter, so it can never wrap.
  always_comb begin
    state_next = state;
    count_next = count;
    pulse_next = 1'b0;
    case (state)
      ST_IDLE: begin
        if (btn_sync) begin
          state_next = ST_PRESS_WAIT;
          count_next = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!btn_sync) begin
          state_next = ST_IDLE;
          count_next = '0;
        end else if (count_done) begin
          state_next = ST_PRESSED;
          count_next = '0;
          pulse_next = 1'b1;
        end else begin
          count_next = count + CNT_W'(1);
        end
      end
      ST_PRESSED: begin
        if (!btn_sync) begin
          state_next = ST_RELEASE_WAIT;
          count_next = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (btn_sync) begin
          state_next = ST_PRESSED;
          count_next = '0;
        end else if (count_done) begin
          state_next = ST_IDLE;
          count_next = '0;
        end else begin
          count_next = count + CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        count_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      count     <= '0;
      btn_pulse <= 1'b0;
      btn_level <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      btn_pulse <= pulse_next;
      btn_level <= (state_next == ST_PRESSED) || (state_next == ST_RELEASE_WAIT);
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner placed in front of the ALU interface: one independent
// debouncer per button, pulses of simultaneous presses land in the same cycle.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int NB_BTN          = 3,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input logic                 i_clk,
  input logic                 i_reset,
  button_conditioner_if.slave btn_if
);

  for (genvar i = 0; i < NB_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
      .clk       (i_clk),
      .rst       (i_reset),
      .btn_raw   (btn_if.i_btn_raw[i]),
      .btn_pulse (btn_if.o_btn_pulse[i]),
      .btn_level (btn_if.o_btn_level[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: run-length reference model checked
// every cycle, directed scenarios with hand-computed edges, then random bouncing.
module tb_button_conditioner;

  localparam int NB = 3;
  localparam int DC = 4;

  logic clk = 1'b0;
  logic rst;
  always #50 clk = ~clk;

  button_conditioner_if #(.NB_BTN(NB)) btn_if ();

  button_conditioner #(
    .NB_BTN          (NB),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .btn_if  (btn_if)
  );

  int total = 0;
  int bad   = 0;
  int edge_no = 0;
  int pulse_cnt [NB];
  int last_pulse_edge [NB];
  int level_high_cnt [NB];
  int all_three_cnt = 0;

  // Reference: a level flips once the synchronized input has held the
  // opposite value for DC+1 consecutive samples; a rise also emits a pulse.
  logic [NB-1:0] m_d1, m_d2, m_prev_y, m_level, m_pulse;
  int m_run [NB];

  function automatic int run_after(int run, logic prev, logic y);
    return (run > 0 && prev == y) ? run + 1 : 1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_d1 <= '0;
      m_d2 <= '0;
      m_prev_y <= '0;
      m_level <= '0;
      m_pulse <= '0;
      for (int i = 0; i < NB; i++) m_run[i] <= 0;
    end else begin
      m_d1 <= btn_if.i_btn_raw;
      m_d2 <= m_d1;
      m_prev_y <= m_d2;
      for (int i = 0; i < NB; i++) begin
        m_run[i] <= run_after(m_run[i], m_prev_y[i], m_d2[i]);
        if (run_after(m_run[i], m_prev_y[i], m_d2[i]) > DC && m_d2[i] != m_level[i]) begin
          m_level[i] <= m_d2[i];
          m_pulse[i] <= m_d2[i];
        end else begin
          m_pulse[i] <= 1'b0;
        end
      end
    end
  end

  always @(posedge clk) edge_no <= edge_no + 1;

  always @(negedge clk) begin
    total = total + 1;
    if (btn_if.o_btn_pulse !== m_pulse || btn_if.o_btn_level !== m_level) begin
      bad = bad + 1;
      $display("[TB] FAIL model_cmp edge=%0d: pulse=%b level=%b, wanted pulse=%b level=%b",
               edge_no, btn_if.o_btn_pulse, btn_if.o_btn_level, m_pulse, m_level);
    end
    for (int i = 0; i < NB; i++) begin
      if (btn_if.o_btn_pulse[i] === 1'b1) begin
        pulse_cnt[i] = pulse_cnt[i] + 1;
        last_pulse_edge[i] = edge_no;
      end
      if (btn_if.o_btn_level[i] === 1'b1) level_high_cnt[i] = level_high_cnt[i] + 1;
    end
    if (btn_if.o_btn_pulse === 3'b111) all_three_cnt = all_three_cnt + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total = total + 1;
    if (actual !== expected) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got %0d, wanted %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NB-1:0] v);
    @(posedge clk);
    #2;
    btn_if.i_btn_raw = v;
  endtask

  task automatic setReset(input logic v);
    @(posedge clk);
    #2;
    rst = v;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  int p, l, a, e0;
  logic [NB-1:0] rv;

  initial begin
    for (int i = 0; i < NB; i++) begin
      pulse_cnt[i] = 0;
      last_pulse_edge[i] = -1;
      level_high_cnt[i] = 0;
    end
    rst = 1'b1;
    btn_if.i_btn_raw = 3'b111;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("reset_pulse", btn_if.o_btn_pulse, 0);
      checkOutput("reset_level", btn_if.o_btn_level, 0);
    end
    btn_if.i_btn_raw = '0;
    setReset(1'b0);
    settle(10);

    // Clean press of bit0: first sample at e0+1, pulse after edge e0+1+DC+2.
    p = pulse_cnt[0];
    applyStimulus(3'b001);
    e0 = edge_no;
    repeat (6) @(posedge clk);
    @(negedge clk);
    checkOutput("press_level_early", btn_if.o_btn_level[0], 0);
    checkOutput("press_pulse_early", btn_if.o_btn_pulse, 0);
    @(negedge clk);
    checkOutput("press_pulse", btn_if.o_btn_pulse, 3'b001);
    checkOutput("press_level", btn_if.o_btn_level[0], 1);
    @(negedge clk);
    checkOutput("press_pulse_drop", btn_if.o_btn_pulse, 0);
    settle(12);
    checkOutput("press_count", pulse_cnt[0] - p, 1);
    applyStimulus(3'b000);
    repeat (6) @(posedge clk);
    @(negedge clk);
    checkOutput("release_level_hold", btn_if.o_btn_level[0], 1);
    @(negedge clk);
    checkOutput("release_level_drop", btn_if.o_btn_level[0], 0);
    settle(5);

    // Bit1 bouncing press and bouncing release.
    p = pulse_cnt[1];
    applyStimulus(3'b010);
    applyStimulus(3'b000);
    applyStimulus(3'b010);
    applyStimulus(3'b000);
    applyStimulus(3'b010);
    e0 = edge_no;
    settle(15);
    checkOutput("bounce_press_count", pulse_cnt[1] - p, 1);
    checkOutput("bounce_press_edge", last_pulse_edge[1], e0 + 7);
    applyStimulus(3'b000);
    applyStimulus(3'b010);
    applyStimulus(3'b000);
    settle(15);
    checkOutput("bounce_release_count", pulse_cnt[1] - p, 1);
    checkOutput("bounce_release_level", btn_if.o_btn_level[1], 0);

    // Bit2 glitches of 3 and DC samples are rejected; DC+1 samples is accepted.
    p = pulse_cnt[2];
    l = level_high_cnt[2];
    repeat (3) applyStimulus(3'b100);
    applyStimulus(3'b000);
    settle(12);
    checkOutput("glitch3_count", pulse_cnt[2] - p, 0);
    checkOutput("glitch3_level", level_high_cnt[2] - l, 0);
    repeat (DC) applyStimulus(3'b100);
    applyStimulus(3'b000);
    settle(12);
    checkOutput("glitch4_count", pulse_cnt[2] - p, 0);
    repeat (DC + 1) applyStimulus(3'b100);
    applyStimulus(3'b000);
    settle(12);
    checkOutput("hold5_count", pulse_cnt[2] - p, 1);

    // All three pressed on the same edge.
    a = all_three_cnt;
    applyStimulus(3'b111);
    e0 = edge_no;
    settle(10);
    checkOutput("all_three_once", all_three_cnt - a, 1);
    for (int i = 0; i < NB; i++) checkOutput("all_three_edge", last_pulse_edge[i], e0 + 7);
    applyStimulus(3'b000);
    settle(12);

    // Reset mid-count discards the press; held button pulses after full latency.
    p = pulse_cnt[0];
    applyStimulus(3'b001);
    repeat (4) @(posedge clk);
    setReset(1'b1);
    repeat (2) @(posedge clk);
    setReset(1'b0);
    e0 = edge_no;
    settle(12);
    checkOutput("reset_mid_count", pulse_cnt[0] - p, 1);
    checkOutput("reset_mid_edge", last_pulse_edge[0], e0 + 7);
    applyStimulus(3'b000);
    settle(12);

    // Random bouncing with occasional resets, checked by the model.
    rv = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NB; b++) begin
        if ($urandom_range(0, 5) == 0) rv[b] = ~rv[b];
      end
      if ($urandom_range(0, 399) == 0) begin
        setReset(1'b1);
        setReset(1'b0);
      end
      applyStimulus(rv);
    end
    settle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
